instr_decode_stage: RTL and testbench

- Registered, flow-controlled MIPS-format decode stage that sits between the fetch buffer and the execute/NoC-issue logic in each core tile.
- Splits a 32-bit instruction into its fields and classifies it as R, I or J type.
- Extends the immediate to DATA_W and forms the jump target from the PC.
- Carries valid/ready handshakes on both sides, a 2-entry skid buffer and a flush.

---
 rtl/instr_decode_stage_if.sv | 40 ++++
 rtl/instr_decode_stage.sv | 124 ++++++++++++
 tb/tb_instr_decode_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - upstream/downstream bundle of the decode stage
// slave is the stage itself; master is the surrounding fetch/execute environment.
interface instr_decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [1:0]        out_itype;
  logic [DATA_W-1:0] out_imm;
  logic [PC_W-1:0]   out_jtarget;
  logic [PC_W-1:0]   out_pc;
  logic              out_illegal;
  logic [31:0]       decoded_count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_itype, out_imm, out_jtarget, out_pc, out_illegal,
           decoded_count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_itype, out_imm, out_jtarget, out_pc, out_illegal,
           decoded_count
  );
endinterface

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered MIPS decode stage with 2-entry skid buffer
// Optional opcode legality check enabled by macro DECODE_ILLEGAL_CHK_EN.
module instr_decode_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [1:0]        itype;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   jtarget;
    logic [PC_W-1:0]   pc;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  function automatic bundle_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    bundle_t         b;
    logic [5:0]      op;
    logic [PC_W-1:0] pc4;
    op        = instr[31:26];
    pc4       = pc + PC_W'(4);
    b.instr   = instr;
    b.pc      = pc;
    if (op == 6'h00)                      b.itype = 2'd0;
    else if (op == 6'h02 || op == 6'h03)  b.itype = 2'd2;
    else                                  b.itype = 2'd1;
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) b.imm = DATA_W'(instr[15:0]);
    else if (op == 6'h0F)                          b.imm = DATA_W'({instr[15:0], 16'h0});
    else b.imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    // Upper PC bits come from the sequential PC; low 28 bits from the word index.
    b.jtarget = (pc4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({instr[25:0], 2'b00});
`ifdef DECODE_ILLEGAL_CHK_EN
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: b.illegal = 1'b0;
      default:                                  b.illegal = 1'b1;
    endcase
`else
    b.illegal = 1'b0;
`endif
    return b;
  endfunction

  state_t      state_q, state_d;
  bundle_t     out_q, skid_q, in_dec;
  logic        in_ready_q;
  logic [31:0] count_q;
  logic        in_fire, out_fire, load_out, skid_to_out, load_skid;

  always_comb begin
    in_dec      = decode(bus.in_instr, bus.in_pc);
    in_fire     = bus.in_valid && in_ready_q;
    out_fire    = (state_q != EMPTY) && bus.out_ready;
    state_d     = state_q;
    load_out    = 1'b0;
    skid_to_out = 1'b0;
    load_skid   = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          load_out = 1'b1;
          state_d  = ONE;
        end
        ONE: begin
          if (out_fire) begin
            load_out = in_fire;
            state_d  = in_fire ? ONE : EMPTY;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: if (out_fire) begin
          skid_to_out = 1'b1;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_out)         out_q <= in_dec;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= in_dec;
      // Output transfers count even in a flush cycle.
      if (out_fire)         count_q <= count_q + 32'd1;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state_q != EMPTY);
  assign bus.out_opcode    = out_q.instr[31:26];
  assign bus.out_rs        = out_q.instr[25:21];
  assign bus.out_rt        = out_q.instr[20:16];
  assign bus.out_rd        = out_q.instr[15:11];
  assign bus.out_shamt     = out_q.instr[10:6];
  assign bus.out_funct     = out_q.instr[5:0];
  assign bus.out_itype     = out_q.itype;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_jtarget   = out_q.jtarget;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_illegal   = out_q.illegal;
  assign bus.decoded_count = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
// Honours DECODE_ILLEGAL_CHK_EN when computing the expected illegal flag.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.DATA_W(32), .PC_W(32)) bus ();
  instr_decode_stage_if #(.DATA_W(64), .PC_W(32)) bus64 ();

  instr_decode_stage #(.DATA_W(32), .PC_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  instr_decode_stage #(.DATA_W(64), .PC_W(32)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  itype;
    logic [63:0] imm;
    logic [31:0] jt;
    logic        illegal;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q[$];
  exp_t        e;
  int unsigned exp_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [159:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t   m;
    int     op;
    longint lo;
`ifdef DECODE_ILLEGAL_CHK_EN
    int legal [15] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
`endif
    op = int'(instr >> 26);
    lo = longint'(instr & 32'hFFFF);
    m.instr = instr;
    m.pc    = pc;
    if (op == 0) m.itype = 2'd0;
    else if (op == 2 || op == 3) m.itype = 2'd2;
    else m.itype = 2'd1;
    if (op >= 12 && op <= 14) m.imm = lo;
    else if (op == 15) m.imm = lo * 65536;
    else if (lo >= 32768) m.imm = lo - 65536;
    else m.imm = lo;
    m.jt = ((pc + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    m.illegal = 1'b0;
`ifdef DECODE_ILLEGAL_CHK_EN
    m.illegal = 1'b1;
    foreach (legal[i]) if (legal[i] == op) m.illegal = 1'b0;
`endif
    return m;
  endfunction

  function automatic logic [159:0] out_snapshot();
    return {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct,
            bus.out_itype, bus.out_imm, bus.out_jtarget, bus.out_pc, bus.out_illegal};
  endfunction

  // Monitor: occupancy, hold, ordered compare, and capture of accepted inputs.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      chk("out_valid_occ", bus.out_valid, q.size() != 0);
      chk("in_ready_occ", bus.in_ready, q.size() < 2);
      chk("decoded_count", bus.decoded_count, exp_cnt);
      if (prev_stall) chk("hold_stable", out_snapshot(), snap);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("opcode", bus.out_opcode, e.instr >> 26);
          chk("rs", bus.out_rs, (e.instr >> 21) & 31);
          chk("rt", bus.out_rt, (e.instr >> 16) & 31);
          chk("rd", bus.out_rd, (e.instr >> 11) & 31);
          chk("shamt", bus.out_shamt, (e.instr >> 6) & 31);
          chk("funct", bus.out_funct, e.instr & 63);
          chk("itype", bus.out_itype, e.itype);
          chk("imm", bus.out_imm, e.imm[31:0]);
          chk("jtarget", bus.out_jtarget, e.jt);
          chk("pc", bus.out_pc, e.pc);
          chk("illegal", bus.out_illegal, e.illegal);
        end
        exp_cnt++;
      end
      if (bus.flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_instr, bus.in_pc));
      prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
      snap       = out_snapshot();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 1, 0);
    step();
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", bus.out_valid, 0);
    step();
  endtask

  int unsigned  saved_cnt;
  logic [31:0]  ops [16] = '{32'h00, 32'h02, 32'h03, 32'h04, 32'h08, 32'h09, 32'h0A, 32'h0C,
                             32'h0D, 32'h0E, 32'h0F, 32'h23, 32'h2B, 32'h3F, 32'h11, 32'h05};

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0;
    bus64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_count", bus.decoded_count, 0);

    // addi $t0,$t1,-4
    step();
    bus.out_ready = 1'b1;
    drive(32'h2128FFFC, 32'h100);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_rs", bus.out_rs, 9);
    chk("addi_rt", bus.out_rt, 8);
    chk("addi_itype", bus.out_itype, 1);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFC);
    step();
    @(negedge clk);
    chk("addi_count", bus.decoded_count, 1);

    // jal with PC in the top segment
    step();
    drive(32'h0C000040, 32'hF000_0000);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("jal_itype", bus.out_itype, 2);
    chk("jal_target", bus.out_jtarget, 32'hF0000100);

    step();
    drive(32'hFC000000, 32'h200);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
`ifdef DECODE_ILLEGAL_CHK_EN
    chk("illegal_flag", bus.out_illegal, 1);
`else
    chk("illegal_flag", bus.out_illegal, 0);
`endif
    drain();

    // Back-pressure: two accepted, third refused until release
    bus.out_ready = 1'b0;
    drive(32'h01095020, 32'h300);
    step();
    drive(32'h8D280010, 32'h304);
    step();
    drive(32'h3C08ABCD, 32'h308);
    @(negedge clk);
    chk("third_refused", bus.in_ready, 0);
    step();
    @(negedge clk);
    chk("third_still_refused", bus.in_ready, 0);
    step();
    bus.out_ready = 1'b1;
    wait_accept();
    drain();

    // Flush while FULL
    bus.out_ready = 1'b0;
    drive(32'h20010001, 32'h400);
    step();
    drive(32'h20020002, 32'h404);
    step();
    drive(32'h20030003, 32'h408);
    bus.flush = 1'b1;
    @(negedge clk);
    saved_cnt = exp_cnt;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_count", bus.decoded_count, saved_cnt);
    step();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] op;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 30) == 0;
      op            = ($urandom % 2 != 0) ? ops[$urandom % 16] : ($urandom % 64);
      bus.in_instr  = (op << 26) | ($urandom & 32'h03FF_FFFF);
      bus.in_pc     = $urandom;
      step();
    end
    drain();

    // Reset with data buffered
    bus.out_ready = 1'b0;
    drive(32'h2004FFFF, 32'h500);
    step();
    drive(32'h2005FFFF, 32'h504);
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_count", bus.decoded_count, 0);
    chk("midrst_imm", bus.out_imm, 0);

    // 64-bit immediate width
    step();
    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h3508FFFF;
    bus64.in_pc    = 32'h600;
    step();
    bus64.in_instr = 32'h3C081234;
    @(negedge clk);
    chk("ori64_imm", bus64.out_imm, 64'h000000000000FFFF);
    e = model(32'h3508FFFF, 32'h600);
    chk("ori64_model", bus64.out_imm, e.imm);
    step();
    bus64.in_valid = 1'b0;
    @(negedge clk);
    chk("lui64_imm", bus64.out_imm, 64'h0000000012340000);
    step();
    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h2128FFFC;
    step();
    bus64.in_valid = 1'b0;
    @(negedge clk);
    chk("addi64_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
